approx_mult_error_monitor: RTL and testbench

- Hardware replacement for the software error-distance metric loop. Sits directly downstream of the 8x8 approximate multiplier.
- Each sample presents the operand pair and the approximate product. The block recomputes the exact product internally.
- Accumulates, over a fixed sample count:
  - error count
  - total error distance (ED)
  - maximum ED
  - relative-ED sum in Q16 fixed point
- Software derives MED and MRED by dividing the ED sum and the relative-ED sum by SAMPLE_COUNT.

---
 rtl/approx_mult_error_monitor.sv | 117 +++++++++++
 tb/tb_approx_mult_error_monitor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_error_monitor.sv
// Error-distance monitor for an 8x8 approximate multiplier: recomputes the exact product,
// accumulates error count, ED sum, max ED and a Q16 relative-ED sum over SAMPLE_COUNT samples.
module approx_mult_error_monitor #(
  parameter int unsigned SAMPLE_COUNT = 65536,
  parameter int unsigned DIV_ITER     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [15:0] in_p,
  output logic        busy,
  output logic        done,
  output logic [31:0] err_count,
  output logic [31:0] sum_ed,
  output logic [15:0] max_ed,
  output logic [47:0] sum_red
);
  localparam int CNT_W = $clog2(SAMPLE_COUNT + 1);
  localparam int IT_W  = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_COUNT);
  localparam logic [IT_W-1:0]  IT_LAST  = IT_W'(DIV_ITER - 1);

  typedef enum logic [1:0] {IDLE, RUN, DIV, DONE} state_t;

  function automatic logic [15:0] abs_ed(input logic [15:0] exact, input logic [15:0] p);
    logic signed [16:0] d;
    d = $signed({1'b0, exact}) - $signed({1'b0, p});
    abs_ed = d[16] ? 16'(-d) : d[15:0];
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [15:0]       exact_p0, ed_p0;
  logic              accept_p0, need_div_p0, last_p0;
  logic [IT_W-1:0]   it_p1;
  logic [31:0]       quo_p1, quo_nxt;
  logic [15:0]       rem_p1, den_p1, rem_nxt;
  logic [16:0]       trial, diff;
  logic              ge;

  // stage p0: exact product and error distance of the offered sample
  assign exact_p0    = 16'(in_a) * 16'(in_b);
  assign ed_p0       = abs_ed(exact_p0, in_p);
  assign accept_p0   = (state == RUN) && in_valid && !start;
  assign need_div_p0 = (ed_p0 != 16'd0) && (exact_p0 != 16'd0);
  assign last_p0     = (cnt + CNT_W'(1)) == CNT_LAST;

  // stage p1: restoring divider, quotient bits shift in where dividend bits shift out
  assign trial   = {rem_p1, quo_p1[31]};
  assign ge      = trial >= {1'b0, den_p1};
  assign diff    = trial - {1'b0, den_p1};
  assign rem_nxt = ge ? 16'(diff) : 16'(trial);
  assign quo_nxt = {quo_p1[30:0], ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept_p0) begin
          if (need_div_p0)  state_nxt = DIV;
          else if (last_p0) state_nxt = DONE;
        end
      end
      DIV: begin
        busy = 1'b1;
        if (it_p1 == IT_LAST) state_nxt = (cnt == CNT_LAST) ? DONE : RUN;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
    if (start) state_nxt = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || start) begin
      cnt       <= '0;
      err_count <= '0;
      sum_ed    <= '0;
      max_ed    <= '0;
      sum_red   <= '0;
      quo_p1    <= '0;
      rem_p1    <= '0;
      den_p1    <= '0;
      it_p1     <= '0;
    end else if (accept_p0) begin
      cnt       <= cnt + CNT_W'(1);
      err_count <= err_count + 32'(ed_p0 != 16'd0);
      sum_ed    <= sum_ed + 32'(ed_p0);
      if (ed_p0 > max_ed) max_ed <= ed_p0;
      if (need_div_p0) begin
        quo_p1 <= {ed_p0, 16'h0000};
        rem_p1 <= '0;
        den_p1 <= exact_p0;
        it_p1  <= '0;
      end
    end else if (state == DIV) begin
      quo_p1 <= quo_nxt;
      rem_p1 <= rem_nxt;
      it_p1  <= it_p1 + IT_W'(1);
      if (it_p1 == IT_LAST) sum_red <= sum_red + 48'(quo_nxt);
    end
  end
endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench for approx_mult_error_monitor: a 4-sample instance for functional cases
// and a 65536-sample instance for the exhaustive exact-product sweep.
`timescale 1ns/1ps
module tb_approx_mult_error_monitor;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_start, s_valid, s_ready, s_busy, s_done;
  logic [7:0]  s_a, s_b;
  logic [15:0] s_p, s_max;
  logic [31:0] s_err, s_sed;
  logic [47:0] s_red;
  logic        x_start, x_valid, x_ready, x_busy, x_done;
  logic [7:0]  x_a, x_b;
  logic [15:0] x_p, x_max;
  logic [31:0] x_err, x_sed;
  logic [47:0] x_red;

  approx_mult_error_monitor #(.SAMPLE_COUNT(4), .DIV_ITER(32)) dut4 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_a(s_a), .in_b(s_b), .in_p(s_p), .busy(s_busy), .done(s_done),
    .err_count(s_err), .sum_ed(s_sed), .max_ed(s_max), .sum_red(s_red));

  approx_mult_error_monitor #(.SAMPLE_COUNT(65536), .DIV_ITER(32)) dut64k (
    .clk(clk), .rst(rst), .start(x_start), .in_valid(x_valid), .in_ready(x_ready),
    .in_a(x_a), .in_b(x_b), .in_p(x_p), .busy(x_busy), .done(x_done),
    .err_count(x_err), .sum_ed(x_sed), .max_ed(x_max), .sum_red(x_red));

  int checks = 0;
  int errors = 0;

  typedef struct {
    longint err, sed, mx, red;
    int     low;
  } exp_t;
  exp_t   sb[$];
  longint m_err, m_sed, m_max, m_red;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_err = 0; m_sed = 0; m_max = 0; m_red = 0;
    sb.delete();
  endtask

  task automatic start4();
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    model_clear();
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_ready"}, 64'(s_ready), 0);
    chk({tag, "_busy"},  64'(s_busy),  0);
    chk({tag, "_done"},  64'(s_done),  0);
    chk({tag, "_err"},   64'(s_err),   0);
    chk({tag, "_sed"},   64'(s_sed),   0);
    chk({tag, "_max"},   64'(s_max),   0);
    chk({tag, "_red"},   64'(s_red),   0);
  endtask

  // Offer one sample, push the model's expected totals, then pop and compare once it settles.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
    int     n;
    exp_t   e;
    longint ex, ed;
    n = 0;
    while (s_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ready_before_send", 64'(s_ready), 1);
    s_valid = 1'b1; s_a = a; s_b = b; s_p = p;
    ex = longint'(a) * longint'(b);
    ed = (ex > longint'(p)) ? ex - longint'(p) : longint'(p) - ex;
    if (ed != 0) m_err++;
    m_sed += ed;
    if (ed > m_max) m_max = ed;
    if (ed != 0 && ex != 0) m_red += (ed << 16) / ex;
    e = '{m_err, m_sed, m_max, m_red, (ed != 0 && ex != 0) ? 32 : 0};
    sb.push_back(e);
    @(negedge clk);
    s_valid = 1'b0;
    n = 0;
    while (s_ready !== 1'b1 && s_done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    e = sb.pop_front();
    chk("ready_low_cycles", 64'(n), 64'(e.low));
    chk("err_count", 64'(s_err), 64'(e.err));
    chk("sum_ed",    64'(s_sed), 64'(e.sed));
    chk("max_ed",    64'(s_max), 64'(e.mx));
    chk("sum_red",   64'(s_red), 64'(e.red));
  endtask

  initial begin
    int stalls;
    rst = 1'b1;
    s_start = 1'($urandom); s_valid = 1'($urandom);
    s_a = 8'($urandom); s_b = 8'($urandom); s_p = 16'($urandom);
    x_start = 1'($urandom); x_valid = 1'($urandom);
    x_a = 8'($urandom); x_b = 8'($urandom); x_p = 16'($urandom);
    @(negedge clk);
    chk_zero4("reset");
    chk("reset_x_ready", 64'(x_ready), 0);
    chk("reset_x_done",  64'(x_done),  0);
    chk("reset_x_err",   64'(x_err),   0);

    rst = 1'b0;
    s_start = 1'b0; x_start = 1'b0; x_valid = 1'b0;
    s_valid = 1'b1; s_a = 8'd3; s_b = 8'd5; s_p = 16'd0;
    repeat (3) @(negedge clk);
    chk("idle_ready", 64'(s_ready), 0);
    chk("idle_busy",  64'(s_busy),  0);
    chk("idle_err",   64'(s_err),   0);
    chk("idle_sed",   64'(s_sed),   0);
    s_valid = 1'b0;

    // mixed run
    start4();
    chk("run_busy",  64'(s_busy),  1);
    chk("run_ready", 64'(s_ready), 1);
    send(8'd3, 8'd5, 16'd15);
    send(8'd3, 8'd5, 16'd14);
    send(8'd0, 8'd7, 16'd2);
    send(8'd10, 8'd10, 16'd96);
    chk("mixed_done",  64'(s_done), 1);
    chk("mixed_busy",  64'(s_busy), 0);
    chk("mixed_err",   64'(s_err),  3);
    chk("mixed_sed",   64'(s_sed),  7);
    chk("mixed_max",   64'(s_max),  4);
    chk("mixed_red",   64'(s_red),  6990);
    s_valid = 1'b1; s_a = 8'd1; s_b = 8'd1; s_p = 16'd9;
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
    chk("frozen_done", 64'(s_done), 1);
    chk("frozen_err",  64'(s_err),  3);
    chk("frozen_sed",  64'(s_sed),  7);
    chk("frozen_red",  64'(s_red),  6990);

    // boundary and zero-exact
    start4();
    send(8'd255, 8'd255, 16'd0);
    chk("bnd_max", 64'(s_max), 65025);
    chk("bnd_red", 64'(s_red), 65536);
    send(8'd0, 8'd9, 16'd5);
    chk("zero_exact_err", 64'(s_err), 2);
    chk("zero_exact_sed", 64'(s_sed), 65030);
    chk("zero_exact_red", 64'(s_red), 65536);
    send(8'd1, 8'd1, 16'd1);
    send(8'd2, 8'd2, 16'd4);
    chk("bnd_done", 64'(s_done), 1);

    // reset in the middle of a division
    start4();
    s_valid = 1'b1; s_a = 8'd3; s_b = 8'd5; s_p = 16'd14;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("middiv_busy",  64'(s_busy),  1);
    chk("middiv_ready", 64'(s_ready), 0);
    chk("middiv_err",   64'(s_err),   1);
    #2 rst = 1'b1;
    #1 chk_zero4("async_reset");
    @(negedge clk);
    rst = 1'b0;

    // start mid-run, with a sample offered in the same cycle
    start4();
    send(8'd0, 8'd9, 16'd5);
    send(8'd0, 8'd3, 16'd1);
    chk("pre_abort_err", 64'(s_err), 2);
    s_start = 1'b1; s_valid = 1'b1; s_a = 8'd0; s_b = 8'd2; s_p = 16'd7;
    @(negedge clk);
    s_start = 1'b0; s_valid = 1'b0;
    model_clear();
    chk("abort_err",   64'(s_err),   0);
    chk("abort_sed",   64'(s_sed),   0);
    chk("abort_max",   64'(s_max),   0);
    chk("abort_red",   64'(s_red),   0);
    chk("abort_ready", 64'(s_ready), 1);
    send(8'd7, 8'd7, 16'd50);
    send(8'd2, 8'd3, 16'd6);
    send(8'd15, 8'd15, 16'd200);
    send(8'd4, 8'd4, 16'd0);
    chk("fresh_done", 64'(s_done), 1);
    chk("fresh_err",  64'(s_err),  3);
    chk("fresh_sed",  64'(s_sed),  42);
    chk("fresh_max",  64'(s_max),  25);
    chk("fresh_red",  64'(s_red),  74154);

    // exhaustive sweep through an exact multiplier
    x_start = 1'b1;
    @(negedge clk);
    x_start = 1'b0;
    stalls = 0;
    for (int i = 0; i < 65536; i++) begin
      x_valid = 1'b1;
      x_a = i[15:8];
      x_b = i[7:0];
      x_p = {8'd0, x_a} * {8'd0, x_b};
      if (x_ready !== 1'b1 || x_done !== 1'b0) stalls++;
      @(negedge clk);
    end
    x_valid = 1'b0;
    chk("sweep_stalls", 64'(stalls), 0);
    chk("sweep_done",   64'(x_done), 1);
    chk("sweep_busy",   64'(x_busy), 0);
    chk("sweep_err",    64'(x_err),  0);
    chk("sweep_sed",    64'(x_sed),  0);
    chk("sweep_max",    64'(x_max),  0);
    chk("sweep_red",    64'(x_red),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
